// File: rtl/uart_tx_param_if.sv
// Producer-side word channel of the parametrised UART transmitter.
//
// Handshake: the producer holds tx_valid, tx_data and the frame
// configuration (parity_en, parity_odd, two_stop) stable while tx_valid
// is high; a word transfers on every rising clk edge where
// tx_valid && tx_ready. tx_ready never depends on tx_valid.
interface uart_tx_param_if #(
    parameter int DATA_W = 8
) ();
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              parity_en;
    logic              parity_odd;
    logic              two_stop;
    logic              tx_ready;

    modport master (
        output tx_valid, tx_data, parity_en, parity_odd, two_stop,
        input  tx_ready
    );

    modport slave (
        input  tx_valid, tx_data, parity_en, parity_odd, two_stop,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: DATA_W data bits LSB first, optional
// even/odd parity, one or two stop bits. A one-entry holding buffer lets
// the next word load on the same edge the previous frame ends, so
// consecutive frames leave no idle gap on the line.
module uart_tx_param #(
    parameter int  DATA_W       = 8,
    parameter int  CLKS_PER_BIT = 8,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_param_if.slave  tx_if,
    output logic            uart_out,
    output logic            lineactive,
    output logic            done,
    output logic [2:0]      dbg_state_o
);

    localparam int IDX_W = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              stop_idx_q, stop_idx_d;

    // Frame in flight: shifted data plus the configuration it was accepted with.
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              two_stop_q, two_stop_d;

    // Holding buffer.
    logic              buf_full_q, buf_full_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic              buf_par_en_q, buf_par_en_d;
    logic              buf_par_odd_q, buf_par_odd_d;
    logic              buf_two_q, buf_two_d;

    logic              uart_q, uart_d;
    logic              line_q, line_d;
    logic              done_q, done_d;

    logic              bit_end;
    logic              last_data;
    logic              frame_end;
    logic              load;
    logic              accept;

    assign bit_end   = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign last_data = (bit_idx_q == IDX_W'(DATA_W - 1));
    assign frame_end = (state_q == S_STOP) && bit_end && (!two_stop_q || stop_idx_q);
    // A buffered word starts either from idle or straight after a frame's last stop bit.
    assign load      = buf_full_q && ((state_q == S_IDLE) || frame_end);
    assign accept    = tx_if.tx_valid && tx_if.tx_ready;

    assign tx_if.tx_ready = !buf_full_q && !rst;
    assign uart_out       = uart_q;
    assign lineactive     = line_q;
    assign done           = done_q;
    assign dbg_state_o    = state_q;

    // State register: every flop of the block, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            stop_idx_q    <= 1'b0;
            shift_q       <= '0;
            par_en_q      <= 1'b0;
            par_bit_q     <= 1'b0;
            two_stop_q    <= 1'b0;
            buf_full_q    <= 1'b0;
            buf_data_q    <= '0;
            buf_par_en_q  <= 1'b0;
            buf_par_odd_q <= 1'b0;
            buf_two_q     <= 1'b0;
            uart_q        <= 1'b1;
            line_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            stop_idx_q    <= stop_idx_d;
            shift_q       <= shift_d;
            par_en_q      <= par_en_d;
            par_bit_q     <= par_bit_d;
            two_stop_q    <= two_stop_d;
            buf_full_q    <= buf_full_d;
            buf_data_q    <= buf_data_d;
            buf_par_en_q  <= buf_par_en_d;
            buf_par_odd_q <= buf_par_odd_d;
            buf_two_q     <= buf_two_d;
            uart_q        <= uart_d;
            line_q        <= line_d;
            done_q        <= done_d;
        end
    end

    // Next-state logic: bit sequencing and bit-time / bit-index / stop-bit counters.
    always_comb begin
        state_d    = state_q;
        cnt_d      = bit_end ? '0 : cnt_q + CNT_W'(1);
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (buf_full_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (last_data) begin
                        state_d    = par_en_q ? S_PARITY : S_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    stop_idx_d = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (two_stop_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        state_d = buf_full_q ? S_START : S_IDLE;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                cnt_d      = '0;
                bit_idx_d  = '0;
                stop_idx_d = 1'b0;
            end
        endcase
    end

    // Output and datapath logic: line level for the next bit, done pulse, buffer.
    always_comb begin
        uart_d        = uart_q;
        line_d        = line_q;
        done_d        = 1'b0;
        shift_d       = shift_q;
        par_en_d      = par_en_q;
        par_bit_d     = par_bit_q;
        two_stop_d    = two_stop_q;
        buf_full_d    = buf_full_q;
        buf_data_d    = buf_data_q;
        buf_par_en_d  = buf_par_en_q;
        buf_par_odd_d = buf_par_odd_q;
        buf_two_d     = buf_two_q;

        case (state_q)
            S_IDLE: begin
                uart_d = 1'b1;
                line_d = 1'b0;
            end
            S_START: begin
                if (bit_end) begin
                    uart_d = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (last_data) begin
                        uart_d = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        uart_d  = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    uart_d = 1'b1;
                end
            end
            S_STOP: begin
                if (frame_end) begin
                    done_d = 1'b1;
                    uart_d = 1'b1;
                    line_d = 1'b0;
                end
            end
            default: begin
                uart_d = 1'b1;
                line_d = 1'b0;
            end
        endcase

        // Loading a word overrides the idle / end-of-frame line level with a start bit.
        if (load) begin
            shift_d    = buf_data_q;
            par_en_d   = buf_par_en_q;
            par_bit_d  = (^buf_data_q) ^ buf_par_odd_q;
            two_stop_d = buf_two_q;
            buf_full_d = 1'b0;
            uart_d     = 1'b0;
            line_d     = 1'b1;
        end

        // Accept and load are exclusive because tx_ready is low while the buffer is full.
        if (accept) begin
            buf_full_d    = 1'b1;
            buf_data_d    = tx_if.tx_data;
            buf_par_en_d  = tx_if.parity_en;
            buf_par_odd_d = tx_if.parity_odd;
            buf_two_d     = tx_if.two_stop;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: an 8-bit instance and a 5-bit instance
// share clock and reset. Each scenario drives words, records the line once
// per cycle, then compares the record against hand-built frames.
module tb_uart_tx_param;

    logic clk;
    logic rst;

    uart_tx_param_if #(.DATA_W(8)) if8 ();
    uart_tx_param_if #(.DATA_W(5)) if5 ();

    logic       uart8, line8, done8;
    logic       uart5, line5, done5;
    logic [2:0] dbg8, dbg5;

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .tx_if       (if8.slave),
        .uart_out    (uart8),
        .lineactive  (line8),
        .done        (done8),
        .dbg_state_o (dbg8)
    );

    uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(8)) dut5 (
        .clk         (clk),
        .rst         (rst),
        .tx_if       (if5.slave),
        .uart_out    (uart5),
        .lineactive  (line5),
        .done        (done5),
        .dbg_state_o (dbg5)
    );

    int n_cmp;
    int n_err;

    // Per-cycle record; index i is sampled just after the i-th edge of a scenario.
    logic       cu8 [0:255];
    logic       cl8 [0:255];
    logic       cd8 [0:255];
    logic       cr8 [0:255];
    logic [2:0] cs8 [0:255];
    logic       cu5 [0:255];
    logic       cl5 [0:255];
    logic       cd5 [0:255];

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic rec(input int i);
        cu8[i] = uart8;
        cl8[i] = line8;
        cd8[i] = done8;
        cr8[i] = if8.tx_ready;
        cs8[i] = dbg8;
        cu5[i] = uart5;
        cl5[i] = line5;
        cd5[i] = done5;
    endtask

    task automatic drive8(input logic v, input logic [7:0] d, input logic pe,
                          input logic po, input logic ts);
        if8.tx_valid   = v;
        if8.tx_data    = d;
        if8.parity_en  = pe;
        if8.parity_odd = po;
        if8.two_stop   = ts;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive8(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        if5.tx_valid = 1'b0; if5.tx_data = 5'h00;
        if5.parity_en = 1'b0; if5.parity_odd = 1'b0; if5.two_stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (uart8 !== 1'b1) begin n_err++; $display("FAIL rst_uart: got %b want 1", uart8); end
        n_cmp++; if (line8 !== 1'b0) begin n_err++; $display("FAIL rst_line: got %b want 0", line8); end
        n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done8); end
        n_cmp++; if (if8.tx_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_in_reset: got %b want 0", if8.tx_ready); end
        n_cmp++; if (dbg8 !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", dbg8); end
        n_cmp++; if (uart5 !== 1'b1) begin n_err++; $display("FAIL rst_uart5: got %b want 1", uart5); end
        rst = 1'b0;
        #1;
        n_cmp++; if (if8.tx_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b want 1", if8.tx_ready); end
        n_cmp++; if (if5.tx_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready5_after: got %b want 1", if5.tx_ready); end
    endtask

    task automatic test_8n1();
        logic [9:0] exp;
        int lc, dc, di;
        exp = {1'b1, 8'hA5, 1'b0};
        n_cmp++; if (if8.tx_ready !== 1'b1) begin n_err++; $display("FAIL 8n1_ready_idle: got %b want 1", if8.tx_ready); end
        drive8(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 90; i++) begin
            @(posedge clk); #1;
            if (i == 0) if8.tx_valid = 1'b0;
            #1; rec(i);
        end
        n_cmp++; if (cu8[0] !== 1'b1) begin n_err++; $display("FAIL 8n1_latency: uart_out at accept+0 %b want 1", cu8[0]); end
        for (int b = 0; b < 10; b++) begin
            logic got; bit ok;
            ok = 1'b1; got = exp[b];
            for (int c = 0; c < 8; c++)
                if (cu8[1 + b*8 + c] !== exp[b]) begin ok = 1'b0; got = cu8[1 + b*8 + c]; end
            n_cmp++; if (!ok) begin n_err++; $display("FAIL 8n1_bit%0d: uart_out %b want %b", b, got, exp[b]); end
        end
        lc = 0; dc = 0; di = -1;
        for (int i = 0; i < 90; i++) begin
            if (cl8[i] === 1'b1) lc++;
            if (cd8[i] === 1'b1) begin dc++; di = i; end
        end
        n_cmp++; if (lc != 80) begin n_err++; $display("FAIL 8n1_line_len: %0d cycles want 80", lc); end
        n_cmp++; if (dc != 1 || di != 81) begin n_err++; $display("FAIL 8n1_done: %0d pulses at %0d want 1 at 81", dc, di); end
        n_cmp++; if (cl8[81] !== 1'b0 || cu8[81] !== 1'b1) begin n_err++; $display("FAIL 8n1_idle_after: line %b uart %b want 0 1", cl8[81], cu8[81]); end
    endtask

    task automatic test_parity();
        logic [10:0] exp;
        int lc, di;
        for (int k = 0; k < 2; k++) begin
            exp = (k == 0) ? {1'b1, 1'b0, 8'h03, 1'b0} : {1'b1, 1'b1, 8'h03, 1'b0};
            drive8(1'b1, 8'h03, 1'b1, k[0], 1'b0);
            for (int i = 0; i < 96; i++) begin
                @(posedge clk); #1;
                if (i == 0) if8.tx_valid = 1'b0;
                #1; rec(i);
            end
            for (int b = 0; b < 11; b++) begin
                logic got; bit ok;
                ok = 1'b1; got = exp[b];
                for (int c = 0; c < 8; c++)
                    if (cu8[1 + b*8 + c] !== exp[b]) begin ok = 1'b0; got = cu8[1 + b*8 + c]; end
                n_cmp++; if (!ok) begin n_err++; $display("FAIL par%0d_bit%0d: uart_out %b want %b", k, b, got, exp[b]); end
            end
            lc = 0; di = -1;
            for (int i = 0; i < 96; i++) begin
                if (cl8[i] === 1'b1) lc++;
                if (cd8[i] === 1'b1) di = i;
            end
            n_cmp++; if (lc != 88) begin n_err++; $display("FAIL par%0d_len: %0d cycles want 88", k, lc); end
            n_cmp++; if (di != 89) begin n_err++; $display("FAIL par%0d_done_at: %0d want 89", k, di); end
        end
    endtask

    task automatic test_two_stop_w5();
        logic [7:0] exp;
        int lc, dc, di;
        exp = {1'b1, 1'b1, 5'h1F, 1'b0};
        n_cmp++; if (if5.tx_ready !== 1'b1) begin n_err++; $display("FAIL w5_ready_idle: got %b want 1", if5.tx_ready); end
        if5.tx_valid = 1'b1; if5.tx_data = 5'h1F;
        if5.parity_en = 1'b0; if5.parity_odd = 1'b0; if5.two_stop = 1'b1;
        for (int i = 0; i < 72; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin if5.tx_valid = 1'b0; if5.two_stop = 1'b0; end
            #1; rec(i);
        end
        for (int b = 0; b < 8; b++) begin
            logic got; bit ok;
            ok = 1'b1; got = exp[b];
            for (int c = 0; c < 8; c++)
                if (cu5[1 + b*8 + c] !== exp[b]) begin ok = 1'b0; got = cu5[1 + b*8 + c]; end
            n_cmp++; if (!ok) begin n_err++; $display("FAIL w5_bit%0d: uart_out %b want %b", b, got, exp[b]); end
        end
        lc = 0; dc = 0; di = -1;
        for (int i = 0; i < 72; i++) begin
            if (cl5[i] === 1'b1) lc++;
            if (cd5[i] === 1'b1) begin dc++; di = i; end
        end
        n_cmp++; if (lc != 64) begin n_err++; $display("FAIL w5_len: %0d cycles want 64", lc); end
        n_cmp++; if (dc != 1 || di != 65) begin n_err++; $display("FAIL w5_done: %0d pulses at %0d want 1 at 65", dc, di); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp;
        int lc, dc, d0, d1;
        bit rdy_ok;
        exp = {1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0};
        drive8(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 170; i++) begin
            @(posedge clk); #1;
            if (i == 0) if8.tx_data = 8'h22;
            if (i == 2) if8.tx_valid = 1'b0;
            #1; rec(i);
        end
        for (int b = 0; b < 20; b++) begin
            logic got; bit ok;
            ok = 1'b1; got = exp[b];
            for (int c = 0; c < 8; c++)
                if (cu8[1 + b*8 + c] !== exp[b]) begin ok = 1'b0; got = cu8[1 + b*8 + c]; end
            n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_bit%0d: uart_out %b want %b", b, got, exp[b]); end
        end
        lc = 0;
        for (int i = 1; i <= 160; i++) if (cl8[i] === 1'b1) lc++;
        n_cmp++; if (lc != 160) begin n_err++; $display("FAIL b2b_line_gap: high %0d of 160 cycles want 160", lc); end
        n_cmp++; if (cl8[161] !== 1'b0) begin n_err++; $display("FAIL b2b_line_end: got %b want 0", cl8[161]); end
        dc = 0; d0 = -1; d1 = -1;
        for (int i = 0; i < 170; i++)
            if (cd8[i] === 1'b1) begin
                if (dc == 0) d0 = i; else d1 = i;
                dc++;
            end
        n_cmp++; if (dc != 2 || d0 != 81 || d1 != 161) begin n_err++; $display("FAIL b2b_done: %0d pulses at %0d,%0d want 2 at 81,161", dc, d0, d1); end
        n_cmp++; if (cr8[1] !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after_load: got %b want 1", cr8[1]); end
        rdy_ok = 1'b1;
        for (int i = 2; i <= 80; i++) if (cr8[i] !== 1'b0) rdy_ok = 1'b0;
        n_cmp++; if (!rdy_ok) begin n_err++; $display("FAIL b2b_ready_low: tx_ready rose while buffer full, want 0"); end
        n_cmp++; if (cr8[81] !== 1'b1) begin n_err++; $display("FAIL b2b_ready_second_load: got %b want 1", cr8[81]); end
    endtask

    task automatic test_config_isolation();
        logic [21:0] exp;
        int lc, dc, d0, d1;
        exp = {1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0};
        drive8(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 190; i++) begin
            @(posedge clk); #1;
            if (i == 0)  if8.tx_valid = 1'b0;
            if (i == 20) drive8(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
            if (i == 21) drive8(1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
            #1; rec(i);
        end
        for (int b = 0; b < 22; b++) begin
            logic got; bit ok;
            ok = 1'b1; got = exp[b];
            for (int c = 0; c < 8; c++)
                if (cu8[1 + b*8 + c] !== exp[b]) begin ok = 1'b0; got = cu8[1 + b*8 + c]; end
            n_cmp++; if (!ok) begin n_err++; $display("FAIL cfg_bit%0d: uart_out %b want %b", b, got, exp[b]); end
        end
        lc = 0; dc = 0; d0 = -1; d1 = -1;
        for (int i = 0; i < 190; i++) begin
            if (cl8[i] === 1'b1) lc++;
            if (cd8[i] === 1'b1) begin
                if (dc == 0) d0 = i; else d1 = i;
                dc++;
            end
        end
        n_cmp++; if (lc != 176) begin n_err++; $display("FAIL cfg_len: %0d cycles want 176", lc); end
        n_cmp++; if (dc != 2 || d0 != 81 || d1 != 177) begin n_err++; $display("FAIL cfg_done: %0d pulses at %0d,%0d want 2 at 81,177", dc, d0, d1); end
    endtask

    task automatic test_reset_mid_frame();
        bit quiet;
        int dc;
        drive8(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (i == 0)  if8.tx_data = 8'hFF;
            if (i == 2)  if8.tx_valid = 1'b0;
            if (i == 30) rst = 1'b1;
            if (i == 31) rst = 1'b0;
            #1; rec(i);
        end
        n_cmp++; if (cr8[10] !== 1'b0) begin n_err++; $display("FAIL rmid_buffered: tx_ready %b want 0", cr8[10]); end
        n_cmp++; if (cs8[30] !== 3'd2) begin n_err++; $display("FAIL rmid_in_data: state %0d want 2", cs8[30]); end
        n_cmp++; if (cu8[31] !== 1'b1 || cl8[31] !== 1'b0) begin n_err++; $display("FAIL rmid_line_after: uart %b line %b want 1 0", cu8[31], cl8[31]); end
        n_cmp++; if (cr8[31] !== 1'b1) begin n_err++; $display("FAIL rmid_ready_after: got %b want 1", cr8[31]); end
        n_cmp++; if (cs8[31] !== 3'd0) begin n_err++; $display("FAIL rmid_state_after: got %0d want 0", cs8[31]); end
        quiet = 1'b1;
        for (int i = 31; i < 200; i++) if (cu8[i] !== 1'b1 || cl8[i] !== 1'b0) quiet = 1'b0;
        n_cmp++; if (!quiet) begin n_err++; $display("FAIL rmid_discard: line active after reset, want idle"); end
        dc = 0;
        for (int i = 0; i < 200; i++) if (cd8[i] === 1'b1) dc++;
        n_cmp++; if (dc != 0) begin n_err++; $display("FAIL rmid_no_done: %0d pulses want 0", dc); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_8n1();
        test_parity();
        test_two_stop_w5();
        test_back_to_back();
        test_config_isolation();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
